tick_scheduler: RTL and testbench

- Shared prescaler controller that produces single-cycle clock-enable strobes for the debouncing and display subsystems, replacing derived slow clocks.
- Two independent channels, each with a runtime-programmable period loaded over a valid/ready configuration port.
- Period changes apply glitch-free at the channel's next tick boundary, or immediately on an explicit restart request.
- Sits between the 8 MHz system clock domain and the debouncer and display scanner, which sample their ticks as enables on the same clock.

---
 rtl/tick_scheduler.sv | 96 +++++++++
 tb/tb_tick_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Two-channel prescaler producing single-cycle clock-enable strobes.
// Latency: a tick is registered one cycle after its counter is seen at zero.
// Backpressure: cfg_ready drops for a channel while it holds a deferred period.
//
// Ports:
//   clock, reset            system clock; asynchronous active-high reset
//   enable                  global run enable, counters hold when low
//   cfg_valid / cfg_ready   configuration handshake (accept on valid && ready)
//   cfg_sel                 0 = debounce channel, 1 = display channel
//   cfg_restart             1 = load now and restart; 0 = load at next tick
//   cfg_period              new period P, tick interval is P+1 enabled cycles
//   tick_debounce           one-cycle strobe, channel 0
//   tick_display            one-cycle strobe, channel 1
//   pending                 bit i set while channel i holds a deferred period
module tick_scheduler #(
    parameter int WIDTH        = 20,
    parameter int DEB_DEFAULT  = 131071,
    parameter int DISP_DEFAULT = 8191
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_sel,
    input  logic             cfg_restart,
    input  logic [WIDTH-1:0] cfg_period,
    output logic             tick_debounce,
    output logic             tick_display,
    output logic [1:0]       pending
);

    localparam logic [WIDTH-1:0] DEB_RST  = WIDTH'(DEB_DEFAULT);
    localparam logic [WIDTH-1:0] DISP_RST = WIDTH'(DISP_DEFAULT);

    // Index 0 = debounce, index 1 = display.
    logic [1:0][WIDTH-1:0] cnt;
    logic [1:0][WIDTH-1:0] per;
    logic [1:0][WIDTH-1:0] pend;
    logic [1:0]            tick;
    logic                  accept;
    logic [1:0]            hit;

    // A channel with a queued deferred value refuses further requests, so a
    // queued value can never be overwritten or discarded by a restart.
    assign cfg_ready = !pending[cfg_sel];
    assign accept    = cfg_valid && cfg_ready;
    assign hit       = accept ? (cfg_sel ? 2'b10 : 2'b01) : 2'b00;

    assign tick_debounce = tick[0];
    assign tick_display  = tick[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= {DISP_RST, DEB_RST};
            per     <= {DISP_RST, DEB_RST};
            pend    <= '0;
            pending <= '0;
            tick    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (hit[i] && cfg_restart) begin
                    // Restart overrides any tick that would fire this cycle.
                    per[i]     <= cfg_period;
                    cnt[i]     <= cfg_period;
                    pending[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end else begin
                    if (enable && (cnt[i] == '0)) begin
                        tick[i] <= 1'b1;
                        if (pending[i]) begin
                            per[i]     <= pend[i];
                            cnt[i]     <= pend[i];
                            pending[i] <= 1'b0;
                        end else begin
                            cnt[i] <= per[i];
                        end
                    end else begin
                        tick[i] <= 1'b0;
                        if (enable) begin
                            cnt[i] <= cnt[i] - WIDTH'(1);
                        end
                    end
                    // A deferred accept is only possible while pending[i] is
                    // clear, so a boundary in this same cycle reloads the old
                    // period and the new one waits for the following boundary.
                    if (hit[i]) begin
                        pend[i]    <= cfg_period;
                        pending[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;

    localparam int W    = 20;
    localparam int DEB  = 131071;
    localparam int DISP = 8191;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         cfg_sel;
    logic         cfg_restart;
    logic [W-1:0] cfg_period;
    logic         tick_debounce;
    logic         tick_display;
    logic [1:0]   pending;

    tick_scheduler dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_sel       (cfg_sel),
        .cfg_restart   (cfg_restart),
        .cfg_period    (cfg_period),
        .tick_debounce (tick_debounce),
        .tick_display  (tick_display),
        .pending       (pending)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: each channel knows how many enabled edges remain until
    // its next tick edge, its active period and an optional queued period.
    int m_per [2];
    int m_rem [2];
    int m_q   [2];
    bit m_qv  [2];
    bit m_tick[2];

    int tq0[$];
    int tq1[$];
    bit last_acc;
    int acc_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_gap(input string tag, input int q[$], input int i, input int exp);
        int obs;
        obs = (q.size() > i + 1) ? q[i+1] - q[i] : -1;
        chk(tag, obs, exp);
    endtask

    task automatic bound_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic model_reset();
        m_per[0] = DEB;  m_rem[0] = DEB + 1;
        m_per[1] = DISP; m_rem[1] = DISP + 1;
        for (int c = 0; c < 2; c++) begin
            m_qv[c]   = 1'b0;
            m_q[c]    = 0;
            m_tick[c] = 1'b0;
        end
    endtask

    // One clock edge: check ready, capture the request, advance the model,
    // then compare ticks and pending just after the edge.
    task automatic step();
        bit acc, rs, en;
        int ch, p;
        #1;
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_qv[cfg_sel]));
        acc = cfg_valid && !m_qv[cfg_sel];
        ch  = int'(cfg_sel);
        rs  = cfg_restart;
        p   = int'(cfg_period);
        en  = enable;
        @(posedge clock);
        cyc++;
        for (int c = 0; c < 2; c++) begin
            if (acc && ch == c && rs) begin
                m_per[c]  = p;
                m_rem[c]  = p + 1;
                m_qv[c]   = 1'b0;
                m_tick[c] = 1'b0;
            end else begin
                m_tick[c] = 1'b0;
                if (en) begin
                    m_rem[c]--;
                    if (m_rem[c] == 0) begin
                        m_tick[c] = 1'b1;
                        if (m_qv[c]) begin
                            m_per[c] = m_q[c];
                            m_qv[c]  = 1'b0;
                        end
                        m_rem[c] = m_per[c] + 1;
                    end
                end
                if (acc && ch == c) begin
                    m_q[c]  = p;
                    m_qv[c] = 1'b1;
                end
            end
        end
        #1;
        chk("tick_debounce", 32'(tick_debounce), 32'(m_tick[0]));
        chk("tick_display", 32'(tick_display), 32'(m_tick[1]));
        chk("pending", 32'(pending), 32'({m_qv[1], m_qv[0]}));
        if (tick_debounce) tq0.push_back(cyc);
        if (tick_display)  tq1.push_back(cyc);
        last_acc = acc;
        if (acc) begin
            cfg_valid = 1'b0;
            acc_cyc   = cyc;
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic cfg(input bit sel, input bit rs, input int p);
        cfg_sel     = sel;
        cfg_restart = rs;
        cfg_period  = W'(p);
        cfg_valid   = 1'b1;
        last_acc    = 1'b0;
        for (int k = 0; k < 64 && !last_acc; k++) step();
        if (!last_acc) begin
            bound_fail("cfg_accept");
            cfg_valid = 1'b0;
        end
    endtask

    task automatic wait_tick(input int ch, input int limit);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            step();
            seen = (ch == 0) ? tick_debounce : tick_display;
        end
        if (!seen) bound_fail("wait_tick");
    endtask

    task automatic step_until_rem(input int ch, input int val, input int limit);
        for (int k = 0; k < limit && m_rem[ch] != val; k++) step();
        if (m_rem[ch] != val) bound_fail("step_until_rem");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, t, rel;
        reset       = 1'b1;
        enable      = 1'b0;
        cfg_valid   = 1'b0;
        cfg_sel     = 1'b0;
        cfg_restart = 1'b0;
        cfg_period  = '0;
        model_reset();

        // Reset state.
        #12;
        chk("rst_tick_debounce", 32'(tick_debounce), 0);
        chk("rst_tick_display", 32'(tick_display), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_ready_sel0", 32'(cfg_ready), 1);
        cfg_sel = 1'b1;
        #1;
        chk("rst_ready_sel1", 32'(cfg_ready), 1);
        @(negedge clock);
        reset  = 1'b0;
        enable = 1'b1;

        // Channel 0 restarted to P=3: first tick 4 edges after accept, then every 4.
        cfg(1'b0, 1'b1, 3);
        a0 = acc_cyc;
        cfg(1'b1, 1'b1, 4);
        steps(13);
        chk("s1_first_deb", (tq0.size() > 0) ? tq0[0] - a0 : -1, 4);
        chk_gap("s1_gap0", tq0, 0, 4);
        chk_gap("s1_gap1", tq0, 1, 4);

        // Channel 1 P=4, deferred P=1 mid-interval: one gap of 5, then 2s.
        wait_tick(1, 20);
        tq1.delete();
        tq1.push_back(cyc);
        steps(2);
        cfg(1'b1, 1'b0, 1);
        chk("s2_pending1", 32'(pending[1]), 1);
        cfg_sel = 1'b1;
        #1;
        chk("s2_ready_sel1", 32'(cfg_ready), 0);
        steps(12);
        chk_gap("s2_gap0", tq1, 0, 5);
        chk_gap("s2_gap1", tq1, 1, 2);
        chk_gap("s2_gap2", tq1, 2, 2);

        // Deferred P=2 accepted in the cnt1==0 cycle with P=4 active.
        cfg(1'b1, 1'b1, 4);
        step_until_rem(1, 1, 20);
        tq1.delete();
        cfg(1'b1, 1'b0, 2);
        chk("s3_coincident_tick", 32'(tick_display), 1);
        steps(15);
        chk_gap("s3_gap0", tq1, 0, 5);
        chk_gap("s3_gap1", tq1, 1, 3);
        chk_gap("s3_gap2", tq1, 2, 3);

        // Restart channel 0 to P=0 on its boundary: tick suppressed, then every cycle.
        step_until_rem(0, 1, 20);
        tq1.delete();
        cfg(1'b0, 1'b1, 0);
        chk("s4_suppressed", 32'(tick_debounce), 0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("s4_every_cycle", 32'(tick_debounce), 1);
        end
        steps(4);
        chk_gap("s4_disp_gap0", tq1, 0, 3);
        chk_gap("s4_disp_gap1", tq1, 1, 3);

        // Enable held low 7 cycles mid-interval with P=3: gap stretches to 11.
        cfg(1'b0, 1'b1, 3);
        wait_tick(0, 10);
        t = cyc;
        step();
        enable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("s5_hold", 32'(tick_debounce), 0);
        end
        enable = 1'b1;
        wait_tick(0, 20);
        chk("s5_gap", cyc - t, 11);

        // Largest legal period loads and counts without wrapping.
        cfg(1'b0, 1'b1, (1 << W) - 1);
        steps(5);
        cfg(1'b0, 1'b1, 2);

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            if (!cfg_valid && $urandom_range(0, 3) == 0) begin
                cfg_sel     = 1'($urandom_range(0, 1));
                cfg_restart = 1'($urandom_range(0, 1));
                cfg_period  = W'($urandom_range(0, 6));
                cfg_valid   = 1'b1;
            end
            enable = ($urandom_range(0, 7) != 0);
            step();
        end
        enable = 1'b1;
        if (cfg_valid) cfg(cfg_sel, cfg_restart, int'(cfg_period));

        // Both channels pending, channel 0 ticking, then asynchronous reset.
        cfg(1'b0, 1'b1, 40);
        cfg(1'b1, 1'b1, 40);
        steps(2);
        cfg(1'b1, 1'b0, 7);
        step_until_rem(0, 1, 50);
        cfg(1'b0, 1'b0, 5);
        chk("s8_pending_both", 32'(pending), 3);
        chk("s8_tick_before_rst", 32'(tick_debounce), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("s8_async_tick_debounce", 32'(tick_debounce), 0);
        chk("s8_async_tick_display", 32'(tick_display), 0);
        chk("s8_async_pending", 32'(pending), 0);
        chk("s8_async_ready", 32'(cfg_ready), 1);
        model_reset();
        @(posedge clock);
        #1;
        chk("s8_held_tick_debounce", 32'(tick_debounce), 0);
        chk("s8_held_tick_display", 32'(tick_display), 0);
        @(negedge clock);
        reset  = 1'b0;
        enable = 1'b1;
        tq1.delete();
        rel = cyc;
        steps(DISP + 5);
        chk("s8_first_display", (tq1.size() > 0) ? tq1[0] - rel : -1, DISP + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
